// File: rtl/sample_framer_if.sv
// Stream bundle for sample_framer: per-channel sample inputs and the 8-bit byte output.
// The framer takes the master view; the surrounding environment takes the slave view.
interface sample_framer_if #(
  parameter int CHANNELS     = 1,
  parameter int SAMPLE_WIDTH = 64
);
  logic [CHANNELS*SAMPLE_WIDTH-1:0] s_tdata;
  logic [CHANNELS-1:0]              s_tvalid;
  logic [CHANNELS-1:0]              s_tready;
  logic [7:0]                       m_tdata;
  logic                             m_tvalid;
  logic                             m_tready;
  logic                             m_tlast;

  modport master (
    input  s_tdata, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    output s_tdata, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/sample_framer.sv
// Round-robin packer of wide sensor samples into SYNC/HDR/payload/CSUM byte frames
// on an 8-bit stream, with a global 4-bit sequence number and a frame counter.
module sample_framer #(
  parameter int          CHANNELS     = 1,
  parameter int          SAMPLE_WIDTH = 64,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  sample_framer_if.master bus,
  output logic [15:0]     frames_sent
);

  localparam int              BYTES     = SAMPLE_WIDTH / 8;
  localparam int              BC_W      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [3:0]      LAST_CH   = 4'(CHANNELS - 1);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    HDR,
    DATA,
    CSUM
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [SAMPLE_WIDTH-1:0] sample_reg;
  logic [SAMPLE_WIDTH-1:0] grant_data;
  logic [3:0]              ch_reg;
  logic [3:0]              seq;
  logic [3:0]              last_served;
  logic [3:0]              grant_idx;
  logic                    grant_valid;
  logic [7:0]              csum;
  logic [7:0]              hdr;
  logic [BC_W-1:0]         byte_cnt;
  logic                    in_fire;
  logic                    out_fire;

  assign hdr      = {seq, ch_reg};
  assign in_fire  = (state == IDLE) && grant_valid;
  assign out_fire = (state != IDLE) && bus.m_tready;

  // Round-robin search: channels above last_served first, then wrap to the low ones.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 4'd0;
    grant_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!grant_valid && bus.s_tvalid[i] && (i > int'(last_served))) begin
        grant_valid = 1'b1;
        grant_idx   = 4'(i);
        grant_data  = bus.s_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!grant_valid && bus.s_tvalid[i] && (i <= int'(last_served))) begin
        grant_valid = 1'b1;
        grant_idx   = 4'(i);
        grant_data  = bus.s_tdata[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_fire) state_next = SYNC;
      SYNC:    if (out_fire) state_next = HDR;
      HDR:     if (out_fire) state_next = DATA;
      DATA:    if (out_fire && (byte_cnt == LAST_BYTE)) state_next = CSUM;
      CSUM:    if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output bytes come straight from registers, so they stay put while stalled.
  always_comb begin
    bus.s_tready = '0;
    bus.m_tvalid = (state != IDLE);
    bus.m_tlast  = (state == CSUM);
    bus.m_tdata  = 8'h00;
    case (state)
      SYNC:    bus.m_tdata = SYNC_BYTE;
      HDR:     bus.m_tdata = hdr;
      DATA:    bus.m_tdata = sample_reg[7:0];
      CSUM:    bus.m_tdata = csum;
      default: bus.m_tdata = 8'h00;
    endcase
    if ((state == IDLE) && grant_valid) begin
      for (int i = 0; i < CHANNELS; i++) begin
        bus.s_tready[i] = (grant_idx == 4'(i));
      end
    end
  end

  // The payload shifts out LSB first; the checksum accumulates each byte as it leaves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_reg  <= '0;
      ch_reg      <= 4'd0;
      seq         <= 4'd0;
      last_served <= LAST_CH;
      csum        <= 8'h00;
      byte_cnt    <= '0;
      frames_sent <= 16'd0;
    end else begin
      if (in_fire) begin
        sample_reg  <= grant_data;
        ch_reg      <= grant_idx;
        last_served <= grant_idx;
        csum        <= 8'h00;
        byte_cnt    <= '0;
      end
      if (out_fire) begin
        case (state)
          HDR: begin
            csum <= csum + hdr;
          end
          DATA: begin
            csum       <= csum + sample_reg[7:0];
            sample_reg <= sample_reg >> 8;
            byte_cnt   <= byte_cnt + 1'b1;
          end
          CSUM: begin
            seq         <= seq + 4'd1;
            frames_sent <= frames_sent + 16'd1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
